snake_stepper: RTL and testbench

Game-step engine for the LED snake. Consumes the one-cycle tick from the upstream 500 µs prescaler and counts ticks to form the game step. On each step it moves the snake head one cell in the committed direction on a wrapping grid. It emits the new head coordinates with a one-cycle `step` strobe for the downstream body/collision and framebuffer logic.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/snake_stepper_step_divider.sv | 40 ++++
 rtl/snake_stepper.sv | 105 ++++++++++
 tb/tb_snake_stepper.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake game types and grid constants, reused by the body, collision and framebuffer blocks.
package snake_pkg;

    localparam int unsigned GRID_W  = 8;
    localparam int unsigned GRID_H  = 8;
    localparam int unsigned COORD_W = 3;
    localparam int unsigned TICK_W  = 16;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } run_state_e;

    // Opposite heading; the snake may never turn back onto itself.
    function automatic dir_t dir_reverse(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_stepper_step_divider.sv
// Counts prescaler ticks and flags the tick that completes a game step; clr holds the count at zero.
module step_divider
    import snake_pkg::*;
#(
    parameter logic [TICK_W-1:0] STEP_TICKS = 16'd200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic tick_i,
    output logic step_en_c
);

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        step_en_c  = 1'b0;
        if (clr_i) begin
            tick_cnt_d = '0;
        end else if (tick_i) begin
            if (tick_cnt_q == STEP_TICKS - TICK_W'(1)) begin
                tick_cnt_d = '0;
                step_en_c  = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/snake_stepper.sv
// Game-step engine: moves the snake head one cell per game step on a wrapping grid,
// with a reverse-direction filter on steering requests.
module snake_stepper #(
    parameter logic [snake_pkg::TICK_W-1:0] STEP_TICKS = 16'd200,
    parameter int unsigned                  GRID_W     = snake_pkg::GRID_W,
    parameter int unsigned                  GRID_H     = snake_pkg::GRID_H,
    parameter int unsigned                  COORD_W    = snake_pkg::COORD_W,
    parameter logic [COORD_W-1:0]           START_X    = COORD_W'(3),
    parameter logic [COORD_W-1:0]           START_Y    = COORD_W'(3),
    parameter logic [1:0]                   START_DIR  = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               tick,
    input  logic [1:0]         dir_req,
    input  logic               dir_req_valid,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [1:0]         dir,
    output logic               step
);

    snake_pkg::run_state_e state_q, state_d;
    snake_pkg::dir_t       dir_q, dir_d;
    snake_pkg::dir_t       pend_q, pend_d;
    snake_pkg::dir_t       commit_c;
    logic [COORD_W-1:0]    x_q, x_d;
    logic [COORD_W-1:0]    y_q, y_d;
    logic                  step_q, step_d;
    logic                  active_c;
    logic                  step_en_c;

    // A tick only counts once the FSM has settled in RUN and en is still high.
    assign active_c = (state_q == snake_pkg::ST_RUN) && en;

    step_divider #(
        .STEP_TICKS(STEP_TICKS)
    ) u_step_divider (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!active_c),
        .tick_i   (tick),
        .step_en_c(step_en_c)
    );

    always_comb begin
        state_d  = en ? snake_pkg::ST_RUN : snake_pkg::ST_PAUSE;
        dir_d    = dir_q;
        pend_d   = pend_q;
        x_d      = x_q;
        y_d      = y_q;
        step_d   = 1'b0;
        commit_c = step_en_c ? pend_q : dir_q;

        if (!active_c) begin
            pend_d = dir_q;
        end else begin
            if (step_en_c) begin
                step_d = 1'b1;
                dir_d  = pend_q;
                // Explicit limit compares so non-power-of-two grids wrap correctly.
                case (pend_q)
                    snake_pkg::DIR_UP:
                        y_d = (y_q == '0) ? COORD_W'(GRID_H - 1) : y_q - COORD_W'(1);
                    snake_pkg::DIR_RIGHT:
                        x_d = (x_q == COORD_W'(GRID_W - 1)) ? '0 : x_q + COORD_W'(1);
                    snake_pkg::DIR_DOWN:
                        y_d = (y_q == COORD_W'(GRID_H - 1)) ? '0 : y_q + COORD_W'(1);
                    snake_pkg::DIR_LEFT:
                        x_d = (x_q == '0) ? COORD_W'(GRID_W - 1) : x_q - COORD_W'(1);
                    default: ;
                endcase
            end
            // Filter against the direction this cycle leaves committed.
            if (dir_req_valid && (snake_pkg::dir_t'(dir_req) != snake_pkg::dir_reverse(commit_c))) begin
                pend_d = snake_pkg::dir_t'(dir_req);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= snake_pkg::ST_PAUSE;
            dir_q   <= snake_pkg::dir_t'(START_DIR);
            pend_q  <= snake_pkg::dir_t'(START_DIR);
            x_q     <= START_X;
            y_q     <= START_Y;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            x_q     <= x_d;
            y_q     <= y_d;
            step_q  <= step_d;
        end
    end

    assign head_x = x_q;
    assign head_y = y_q;
    assign dir    = dir_q;
    assign step   = step_q;

endmodule

// File: tb/tb_snake_stepper.sv
// Scoreboard bench for snake_stepper with STEP_TICKS=4 on the default 8x8 grid.
module tb_snake_stepper;

    localparam int ST = 4;
    localparam int GW = 8;
    localparam int GH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic       dir_req_valid = 1'b0;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic [1:0] dir;
    logic       step;

    always #5 clk = ~clk;

    snake_stepper #(
        .STEP_TICKS(16'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .tick         (tick),
        .dir_req      (dir_req),
        .dir_req_valid(dir_req_valid),
        .head_x       (head_x),
        .head_y       (head_y),
        .dir          (dir),
        .step         (step)
    );

    typedef struct {
        int cyc;
        int x;
        int y;
        int d;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   m_run, m_cnt, m_pend, m_dir, m_x, m_y;

    task automatic chk(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_cnt  = 0;
        m_pend = 1;
        m_dir  = 1;
        m_x    = 3;
        m_y    = 3;
        exp_q.delete();
    endtask

    // Reference behaviour for one clock edge with the given inputs.
    task automatic model_edge(input logic e, input logic t, input logic v, input logic [1:0] r);
        bit qual;
        int committed;
        qual = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_run != 0 && e) begin
            if (t) begin
                if (m_cnt == ST - 1) begin
                    qual  = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            committed = qual ? m_pend : m_dir;
            if (qual) begin
                m_dir = m_pend;
                case (m_dir)
                    0:       m_y = (m_y + GH - 1) % GH;
                    1:       m_x = (m_x + 1) % GW;
                    2:       m_y = (m_y + 1) % GH;
                    default: m_x = (m_x + GW - 1) % GW;
                endcase
                exp_q.push_back('{cyc_n + 1, m_x, m_y, m_dir});
            end
            if (v && int'(r) != (committed ^ 2)) m_pend = int'(r);
        end else begin
            m_cnt  = 0;
            m_pend = m_dir;
        end
        m_run = e ? 1 : 0;
    endtask

    task automatic cyc(input logic e, input logic t, input logic v, input logic [1:0] r);
        en            = e;
        tick          = t;
        dir_req_valid = v;
        dir_req       = r;
        model_edge(e, t, v, r);
        @(posedge clk);
        #1;
        cyc_n++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
            chk("step", int'(step), 1);
            chk("step_x", int'(head_x), exp_q[0].x);
            chk("step_y", int'(head_y), exp_q[0].y);
            chk("step_dir", int'(dir), exp_q[0].d);
            void'(exp_q.pop_front());
        end else begin
            chk("no_step", int'(step), 0);
        end
        chk("head_x", int'(head_x), m_x);
        chk("head_y", int'(head_y), m_y);
        chk("dir", int'(dir), m_dir);
    endtask

    // Ticks every cycle until the model's qualifying tick; optional request on that cycle.
    task automatic run_to_step(input logic v, input logic [1:0] r, output int n);
        bit hit;
        hit = 0;
        n   = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            hit = (m_run != 0) && (m_cnt == ST - 1);
            cyc(1'b1, 1'b1, v && hit, r);
            n++;
        end
        if (!hit) chk("step_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int xs[5];
        xs = '{4, 5, 6, 7, 0};
        model_reset();

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;

        // Run right along row 3, wrapping at the grid edge.
        cyc(1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            run_to_step(1'b0, 2'b00, n);
            chk("wrap_x_seq", int'(head_x), xs[i]);
            chk("row_hold", int'(head_y), 3);
        end

        // UP accepted, LEFT (reverse of RIGHT) rejected.
        cyc(1'b1, 1'b1, 1'b1, 2'b00);
        cyc(1'b1, 1'b1, 1'b1, 2'b11);
        run_to_step(1'b0, 2'b00, n);
        chk("rev_dir", int'(dir), 0);
        chk("rev_y", int'(head_y), 2);

        // Climb to row 0 then wrap to row 7.
        run_to_step(1'b0, 2'b00, n);
        run_to_step(1'b0, 2'b00, n);
        chk("up_y0", int'(head_y), 0);
        run_to_step(1'b0, 2'b00, n);
        chk("up_wrap_y", int'(head_y), 7);
        chk("up_wrap_step", int'(step), 1);

        // Pause with 3 of 4 ticks counted; the first paused cycle carries a qualifying tick.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 2'b01);
        chk("pause_x", int'(head_x), 0);
        chk("pause_y", int'(head_y), 7);
        cyc(1'b1, 1'b1, 1'b0, 2'b00);
        run_to_step(1'b0, 2'b00, n);
        chk("resume_ticks", n, 4);
        chk("pause_req_ignored", int'(dir), 0);
        chk("resume_y", int'(head_y), 6);

        // Simultaneous request and qualifying tick.
        cyc(1'b1, 1'b1, 1'b1, 2'b01);
        run_to_step(1'b0, 2'b00, n);
        chk("turn_right_x", int'(head_x), 1);
        run_to_step(1'b1, 2'b10, n);
        chk("sim_old_dir", int'(dir), 1);
        chk("sim_x", int'(head_x), 2);
        run_to_step(1'b0, 2'b00, n);
        chk("sim_next_dir", int'(dir), 2);
        chk("sim_next_y", int'(head_y), 7);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
        end

        // Asynchronous reset asserted mid-cycle while step is high.
        cyc(1'b1, 1'b1, 1'b0, 2'b00);
        run_to_step(1'b0, 2'b00, n);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_x", int'(head_x), 3);
        chk("arst_y", int'(head_y), 3);
        chk("arst_dir", int'(dir), 1);
        chk("arst_step", int'(step), 0);
        model_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 2'b10);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 2'b00);
        run_to_step(1'b0, 2'b00, n);
        chk("post_rst_x", int'(head_x), 4);
        chk("post_rst_ticks", n, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
